fp_compare_unit: RTL
====================

FP_COMPARE_UNIT -- requirements
Module: fp_compare_unit

Interface
REQ-001 SHALL have parameter TAG_WIDTH, default 8, width of the per-operation tag carried through the pipeline.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of the saturating invalid-operation counter.
REQ-003 SHALL have port clk  input  1  single clock, all state on the rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operation offered.
REQ-006 SHALL have port in_ready  output  1  operation accepted when in_valid && in_ready.
REQ-007 SHALL have port in_op  input  3  0=FEQ, 1=FLT, 2=FLE, 3=FMIN, 4=FMAX, 5..7 reserved.
REQ-008 SHALL have ports in_a and in_b  input  32 each  IEEE 754 single-precision operands.
REQ-009 SHALL have port in_tag  input  TAG_WIDTH  opaque tag returned with the result.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  result consumed when out_valid && out_ready.
REQ-012 SHALL have port out_result  output  32  compare result (0/1, zero-extended) or min/max value.
REQ-013 SHALL have port out_invalid  output  1  IEEE invalid-operation flag for this result.
REQ-014 SHALL have port out_tag  output  TAG_WIDTH  tag of this result.
REQ-015 SHALL have port inv_count  output  CNT_WIDTH  saturating count of results delivered with out_invalid=1.
REQ-016 SHALL have port inv_count_clr  input  1  synchronous clear of inv_count.

Function
REQ-017 SHALL be a two-stage pipeline: S1 registers operands, op, tag and per-operand class (zero/inf/qNaN/sNaN/denormal/normal); S2 registers the result, flag and tag.
REQ-018 SHALL deliver a result two cycles after acceptance when out_ready is held high, with a sustained throughput of one operation per cycle.
REQ-019 SHALL stall when out_valid && !out_ready: S2 holds, S1 advances only into an empty or draining S2, and in_ready = !S1_valid || S1 advancing; no operation is lost or duplicated.
REQ-020 SHALL hold out_result, out_invalid and out_tag stable while out_valid && !out_ready.
REQ-021 SHALL implement FEQ as a quiet compare: result 1 iff neither operand is NaN and the values are equal (+0 == -0); out_invalid iff either operand is sNaN.
REQ-022 SHALL implement FLT and FLE as signaling compares: result 0 if either operand is NaN; out_invalid iff either operand is NaN (quiet or signaling).
REQ-023 SHALL order values as follows: -inf < negative < -0 == +0 < positive < +inf, with denormals ordered by magnitude.
REQ-024 SHALL implement FMIN/FMAX: if exactly one operand is NaN, return the other; if both are NaN, return 0x7FC00000; otherwise return the lesser/greater value, treating -0 as less than +0; out_invalid iff either operand is sNaN.
REQ-025 SHALL, for reserved ops, return result 0 with out_invalid=1.
REQ-026 SHALL increment inv_count by 1 on each handshake with out_invalid=1, saturating at all-ones; inv_count_clr takes priority over a simultaneous increment.

Reset
REQ-027 SHALL, while rst is high, clear both stage valids, giving out_valid=0 and in_ready=0; out_result=0, out_invalid=0, out_tag=0, inv_count=0.
REQ-028 SHALL discard any in-flight operations when rst asserts mid-operation, and SHALL drive in_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-029 SHALL, when OPENGPU_FP_FTZ_EN is defined, flush denormal operands in S1 to a zero of the same sign before any compare or min/max, so that returned values are also flushed.
REQ-030 SHALL, when OPENGPU_FP_FTZ_EN is not defined, compare denormals exactly and return them unmodified.

Verification
REQ-031 SHALL verify: FEQ a=0x00000000, b=0x80000000 -> result 1, invalid 0; FLT with the same operands -> result 0.
REQ-032 SHALL verify: FLE a=0x7FC00000, b=0x3F800000 -> result 0, invalid 1, inv_count 0->1; FEQ with the same operands -> invalid 0.
REQ-033 SHALL verify: FMIN a=0x7F800001 (sNaN), b=0xBF800000 -> result 0xBF800000, invalid 1; FMAX a=b=0x7FC00000 -> result 0x7FC00000, invalid 0.
REQ-034 SHALL verify: FMAX a=0x00000001, b=0x00000000 -> 0x00000001 without the macro, 0x00000000 with OPENGPU_FP_FTZ_EN.
REQ-035 SHALL verify: issue 4 back-to-back ops with out_ready=0 for 5 cycles -> in_ready falls after 2 accepted; on release, tags emerge in order with no loss.
REQ-036 SHALL verify: assert rst with 2 ops in flight -> out_valid=0 next cycle, inv_count=0, and no stale results after release.

Source files
------------

// File: rtl/fp_compare_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : fp_compare_unit                                             |
// | Purpose  : Two-stage IEEE 754 single-precision compare / min / max     |
// |            unit with valid/ready flow control, per-op tag passthrough  |
// |            and a saturating invalid-operation counter.                 |
// | Ports    : clk, rst (sync, active-high)                                |
// |            in_valid/in_ready, in_op[2:0], in_a, in_b, in_tag  (input)  |
// |            out_valid/out_ready, out_result, out_invalid, out_tag       |
// |            inv_count (saturating), inv_count_clr (sync clear)          |
// | Config   : define OPENGPU_FP_FTZ_EN to flush denormal operands to a    |
// |            signed zero in S1 (results are flushed too).                |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module fp_compare_unit #(
  parameter int TAG_WIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_op,
  input  logic [31:0]          in_a,
  input  logic [31:0]          in_b,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_result,
  output logic                 out_invalid,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic [CNT_WIDTH-1:0] inv_count,
  input  logic                 inv_count_clr
);

  localparam logic [2:0]  c_OP_FEQ    = 3'd0;
  localparam logic [2:0]  c_OP_FLT    = 3'd1;
  localparam logic [2:0]  c_OP_FLE    = 3'd2;
  localparam logic [2:0]  c_OP_FMIN   = 3'd3;
  localparam logic [2:0]  c_OP_FMAX   = 3'd4;
  localparam logic [31:0] c_CANON_NAN = 32'h7FC0_0000;
  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    CLS_ZERO   = 3'd0,
    CLS_DENORM = 3'd1,
    CLS_NORMAL = 3'd2,
    CLS_INF    = 3'd3,
    CLS_QNAN   = 3'd4,
    CLS_SNAN   = 3'd5
  } fp_class_e;

  function automatic fp_class_e classify(input logic [31:0] x);
    fp_class_e c;
    if (x[30:23] == 8'hFF) begin
      if (x[22:0] == 23'd0) c = CLS_INF;
      else if (x[22])       c = CLS_QNAN;
      else                  c = CLS_SNAN;
    end else if (x[30:23] == 8'h00) begin
      c = (x[22:0] == 23'd0) ? CLS_ZERO : CLS_DENORM;
    end else begin
      c = CLS_NORMAL;
    end
    return c;
  endfunction

  // Denormal handling at the S1 input; with flushing enabled the stored
  // operand itself is the signed zero, so min/max return flushed values.
  function automatic logic [31:0] flush_den(input logic [31:0] x);
`ifdef OPENGPU_FP_FTZ_EN
    return (x[30:23] == 8'h00) ? {x[31], 31'd0} : x;
`else
    return x;
`endif
  endfunction

  // Monotonic unsigned key over non-NaN values: negatives are bit-inverted,
  // positives get the top bit set. This orders -0 just below +0, which is
  // what min/max need; the compares treat the two zeros as equal separately.
  function automatic logic [31:0] ord_key(input logic [31:0] x);
    return x[31] ? ~x : {1'b1, x[30:0]};
  endfunction

  // ---------------- state ----------------
  logic                 s1_valid_q, s1_valid_d;
  logic [2:0]           s1_op_q,    s1_op_d;
  logic [31:0]          s1_a_q,     s1_a_d;
  logic [31:0]          s1_b_q,     s1_b_d;
  logic [TAG_WIDTH-1:0] s1_tag_q,   s1_tag_d;
  fp_class_e            s1_cls_a_q, s1_cls_a_d;
  fp_class_e            s1_cls_b_q, s1_cls_b_d;

  logic                 s2_valid_q,   s2_valid_d;
  logic [31:0]          s2_result_q,  s2_result_d;
  logic                 s2_invalid_q, s2_invalid_d;
  logic [TAG_WIDTH-1:0] s2_tag_q,     s2_tag_d;

  logic [CNT_WIDTH-1:0] inv_count_q, inv_count_d;

  // ---------------- flow control ----------------
  logic s2_adv;
  logic s1_adv;
  logic accept;
  logic in_ready_w;

  always_comb begin
    s2_adv     = !s2_valid_q || out_ready;
    s1_adv     = s1_valid_q && s2_adv;
    in_ready_w = !rst && (!s1_valid_q || s2_adv);
    accept     = in_valid && in_ready_w;
  end

  // ---------------- S1 next state ----------------
  logic [31:0] a_flushed;
  logic [31:0] b_flushed;

  always_comb begin
    a_flushed  = flush_den(in_a);
    b_flushed  = flush_den(in_b);
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_tag_d   = s1_tag_q;
    s1_cls_a_d = s1_cls_a_q;
    s1_cls_b_d = s1_cls_b_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_op_d    = in_op;
      s1_a_d     = a_flushed;
      s1_b_d     = b_flushed;
      s1_tag_d   = in_tag;
      s1_cls_a_d = classify(a_flushed);
      s1_cls_b_d = classify(b_flushed);
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // ---------------- S2 compute ----------------
  logic        a_nan, b_nan, any_nan, any_snan, both_zero;
  logic        eq, lt;
  logic [31:0] lesser, greater;
  logic [31:0] res;
  logic        inv;

  always_comb begin
    a_nan     = (s1_cls_a_q == CLS_QNAN) || (s1_cls_a_q == CLS_SNAN);
    b_nan     = (s1_cls_b_q == CLS_QNAN) || (s1_cls_b_q == CLS_SNAN);
    any_nan   = a_nan || b_nan;
    any_snan  = (s1_cls_a_q == CLS_SNAN) || (s1_cls_b_q == CLS_SNAN);
    both_zero = (s1_cls_a_q == CLS_ZERO) && (s1_cls_b_q == CLS_ZERO);
    eq        = both_zero || (s1_a_q == s1_b_q);
    lt        = !both_zero && (ord_key(s1_a_q) < ord_key(s1_b_q));
    lesser    = (ord_key(s1_a_q) < ord_key(s1_b_q)) ? s1_a_q : s1_b_q;
    greater   = (ord_key(s1_a_q) < ord_key(s1_b_q)) ? s1_b_q : s1_a_q;
    res       = 32'd0;
    inv       = 1'b0;
    case (s1_op_q)
      c_OP_FEQ: begin
        res = {31'd0, !any_nan && eq};
        inv = any_snan;
      end
      c_OP_FLT: begin
        res = {31'd0, !any_nan && lt};
        inv = any_nan;
      end
      c_OP_FLE: begin
        res = {31'd0, !any_nan && (lt || eq)};
        inv = any_nan;
      end
      c_OP_FMIN, c_OP_FMAX: begin
        if (a_nan && b_nan)  res = c_CANON_NAN;
        else if (a_nan)      res = s1_b_q;
        else if (b_nan)      res = s1_a_q;
        else                 res = (s1_op_q == c_OP_FMIN) ? lesser : greater;
        inv = any_snan;
      end
      default: begin
        res = 32'd0;
        inv = 1'b1;
      end
    endcase
  end

  // ---------------- S2 next state and counter ----------------
  always_comb begin
    s2_valid_d   = s2_valid_q;
    s2_result_d  = s2_result_q;
    s2_invalid_d = s2_invalid_q;
    s2_tag_d     = s2_tag_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_result_d  = res;
        s2_invalid_d = inv;
        s2_tag_d     = s1_tag_q;
      end
    end

    inv_count_d = inv_count_q;
    if (inv_count_clr) begin
      inv_count_d = '0;
    end else if (s2_valid_q && out_ready && s2_invalid_q && (inv_count_q != '1)) begin
      inv_count_d = inv_count_q + c_CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_op_q      <= 3'd0;
      s1_a_q       <= 32'd0;
      s1_b_q       <= 32'd0;
      s1_tag_q     <= '0;
      s1_cls_a_q   <= CLS_ZERO;
      s1_cls_b_q   <= CLS_ZERO;
      s2_valid_q   <= 1'b0;
      s2_result_q  <= 32'd0;
      s2_invalid_q <= 1'b0;
      s2_tag_q     <= '0;
      inv_count_q  <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_op_q      <= s1_op_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_tag_q     <= s1_tag_d;
      s1_cls_a_q   <= s1_cls_a_d;
      s1_cls_b_q   <= s1_cls_b_d;
      s2_valid_q   <= s2_valid_d;
      s2_result_q  <= s2_result_d;
      s2_invalid_q <= s2_invalid_d;
      s2_tag_q     <= s2_tag_d;
      inv_count_q  <= inv_count_d;
    end
  end

  assign in_ready    = in_ready_w;
  assign out_valid   = s2_valid_q;
  assign out_result  = s2_result_q;
  assign out_invalid = s2_invalid_q;
  assign out_tag     = s2_tag_q;
  assign inv_count   = inv_count_q;

endmodule
`default_nettype wire
